ahb_bus_arbiter: RTL and testbench
==================================

// Module: ahb_bus_arbiter
// PURPOSE
//  Shares the AHB address/data bus among NUM_MASTERS requesting masters in front of the slave fabric.
//  - Grants one master at a time, round-robin by default.
//  - Holds the grant for fixed-length bursts, undefined-length INCR bursts and locked sequences.
//  - Drives the address-phase and data-phase owner IDs that steer the master mux and the HSEL/HREADY path.
// PARAMETERS
//  NUM_MASTERS     4  number of requesting masters (2..16)
//  MID_W           2  owner-ID width, = clog2(NUM_MASTERS)
//  DEFAULT_MASTER  0  parked owner when nobody requests
// PORTS
//  HCLK_i         in   1            bus clock, all state on rising edge
//  HRESETn_i      in   1            reset, asynchronous assert, active-low
//  HBUSREQ_i      in   NUM_MASTERS  per-master bus request
//  HLOCK_i        in   NUM_MASTERS  per-master locked-transfer request
//  HTRANS_i       in   2            muxed HTRANS of current address-phase owner (00 IDLE,01 BUSY,10 NONSEQ,11 SEQ)
//  HBURST_i       in   3            muxed HBURST of owner (000 SINGLE,001 INCR,010/011 WRAP4/INCR4,100/101 x8,110/111 x16)
//  HREADY_i       in   1            bus-wide ready; 1 = current data phase completes this edge
//  HGRANT_o       out  NUM_MASTERS  one-hot grant, registered
//  HMASTER_o      out  MID_W        address-phase owner ID
//  HMASTDATA_o    out  MID_W        data-phase owner ID (steers HWDATA mux)
//  HMASTLOCK_o    out  1            current address phase is locked
// BEHAVIOUR
//  Reset (async, HRESETn_i=0):
//   - HGRANT_o=onehot(DEFAULT_MASTER); HMASTER_o=HMASTDATA_o=DEFAULT_MASTER; HMASTLOCK_o=0.
//   - FSM=ARB; beat counter=0; RR pointer=DEFAULT_MASTER.
//  FSM states: ARB (free to re-grant), BURST (fixed burst in progress), INCR (undefined burst), LOCK.
//   - ARB->BURST: NONSEQ accepted (HREADY_i=1) with HBURST_i in 010..111; counter loads beats-1 (3/7/15).
//   - ARB->INCR:  NONSEQ accepted with HBURST_i=001.
//   - ARB->LOCK:  HLOCK_i[owner]=1 at the accepting edge. LOCK has priority over BURST/INCR.
//   - BURST: counter decrements on each SEQ accepted; ->ARB at the edge accepting the beat with counter=0.
//     BUSY and IDLE do not decrement.
//   - INCR: ->ARB when HBUSREQ_i[owner]=0 and HREADY_i=1.
//   - LOCK: ->ARB at first edge with HLOCK_i[owner]=0 and HREADY_i=1 (the locked transfer has completed).
//   - SINGLE accepted in ARB: stays in ARB.
//  Re-grant:
//   - HGRANT_o updates only at edges where FSM is (or is returning to) ARB and HREADY_i=1.
//   - Winner = first requester at or after RR pointer+1, modulo NUM_MASTERS; pointer <= winner.
//   - No requester: grant parks on DEFAULT_MASTER; pointer unchanged.
//  Ownership pipeline, each stage only on HREADY_i=1:
//   - HMASTER_o <= index(HGRANT_o).
//   - HMASTDATA_o <= HMASTER_o.
//   - HMASTLOCK_o <= HLOCK_i[index(HGRANT_o)].
//   - Grant-to-address-ownership latency = 1 ready edge; data ownership follows one ready edge later.
//  HREADY_i=0: every register holds, including grant and FSM (wait states are transparent).
//  Boundary cases:
//   - Owner re-requests with others waiting: RR passes grant onward; sole requester keeps it.
//   - Master drops HBUSREQ mid fixed burst: grant held until the burst's last beat.
//   - HLOCK_i on a non-owner: ignored.
//   - Early-terminated burst (NONSEQ/IDLE seen in BURST): ->ARB immediately, counter cleared.
//   - Reset mid-burst: immediate return to reset values; no partial state survives.
// CONFIGURATION
//  AHB_ARB_FIXED_PRIO_EN
//   - Defined: fixed priority, lowest index wins; RR pointer logic is removed.
//   - Undefined: round-robin as above.
//  All other behaviour is identical in both builds.
// STRUCTURE
//  - Package ahb_pkg: HTRANS_* and HBURST_* localparam encodings, arbiter state enum typedef,
//    burst_beats(HBURST) constant function.
//  - Sub-module ahb_rr_picker: combinational masked priority pick
//    (req vector + pointer -> one-hot winner + valid); fixed-priority mode ties pointer to NUM_MASTERS-1.
// TESTING
//  1. Reset with HBUSREQ_i=4'b0000 -> HGRANT_o=4'b0001, HMASTER_o=0, HMASTLOCK_o=0.
//  2. HBUSREQ_i=4'b1111, SINGLE transfers, HREADY_i=1 -> grant rotates 1,2,3,0,1 on successive edges.
//  3. M2 NONSEQ INCR4 with M1 requesting -> grant held on M2 for exactly 4 accepted beats,
//     moves to M1 at the 4th; 2 inserted BUSY cycles do not shorten the hold.
//  4. M3 HLOCK_i=1, HREADY_i toggled low 3 cycles -> grant and HMASTLOCK_o=1 held;
//     released only after HLOCK drop plus HREADY_i=1.
//  5. HREADY_i=0 during grant change -> HMASTER_o/HMASTDATA_o frozen;
//     HMASTDATA_o lags HMASTER_o by one ready edge.
//  6. HRESETn_i low mid-INCR8 (beat 5) -> outputs at reset values asynchronously; FSM=ARB after release.
//     Repeat test 2 with AHB_ARB_FIXED_PRIO_EN -> M0 wins every arbitration.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB encodings and arbiter types.
// Purpose : HTRANS/HBURST encodings, arbiter state enum and the burst length
//           helper used by ahb_bus_arbiter.
// Ports   : none (package).
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    // ST_ARB: free to re-grant; ST_BURST: fixed-length burst;
    // ST_INCR: undefined-length burst; ST_LOCK: locked sequence.
    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_BURST = 2'd1,
        ST_INCR  = 2'd2,
        ST_LOCK  = 2'd3
    } arb_state_e;

    // Beat count of a burst type; 1 for SINGLE, 0 for undefined-length INCR.
    function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
        logic [4:0] beats;
        case (hburst)
            HBURST_SINGLE:               beats = 5'd1;
            HBURST_INCR:                 beats = 5'd0;
            HBURST_WRAP4,  HBURST_INCR4:  beats = 5'd4;
            HBURST_WRAP8,  HBURST_INCR8:  beats = 5'd8;
            HBURST_WRAP16, HBURST_INCR16: beats = 5'd16;
            default:                     beats = 5'd1;
        endcase
        return beats;
    endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Masked priority picker.
// Purpose : picks the first requester strictly above ptr_i, wrapping to the
//           lowest requester; combinational, no state.
// Ports   : req_i (request vector), ptr_i (last winner), gnt_o (one-hot
//           winner), vld_o (any request present).
module ahb_rr_picker #(
    parameter int NUM_MASTERS = 4,
    parameter int MID_W       = 2
) (
    input  logic [NUM_MASTERS-1:0] req_i,
    input  logic [MID_W-1:0]       ptr_i,
    output logic [NUM_MASTERS-1:0] gnt_o,
    output logic                   vld_o
);

    logic [NUM_MASTERS-1:0] gnt_hi;
    logic [NUM_MASTERS-1:0] gnt_lo;
    logic                   hi_found;
    logic                   lo_found;

    // gnt_hi searches the masked (above pointer) half, gnt_lo the whole
    // vector; the masked result wins whenever it finds anyone.
    always_comb begin
        gnt_hi   = '0;
        gnt_lo   = '0;
        hi_found = 1'b0;
        lo_found = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (req_i[i] && !hi_found && (i > int'(ptr_i))) begin
                gnt_hi[i] = 1'b1;
                hi_found  = 1'b1;
            end
            if (req_i[i] && !lo_found) begin
                gnt_lo[i] = 1'b1;
                lo_found  = 1'b1;
            end
        end
        gnt_o = hi_found ? gnt_hi : gnt_lo;
    end

    assign vld_o = |req_i;

endmodule

// File: rtl/ahb_bus_arbiter.sv
// AHB bus arbiter: one-hot grant, address/data owner IDs and lock flag.
// Purpose : round-robin grant (fixed priority, lowest index, when
//           AHB_ARB_FIXED_PRIO_EN is defined), held through fixed bursts,
//           INCR bursts and locked sequences.
// Ports   : HCLK_i/HRESETn_i clock and async active-low reset; HBUSREQ_i,
//           HLOCK_i per-master requests; HTRANS_i/HBURST_i of the address
//           owner; HREADY_i bus ready (0 freezes all state); HGRANT_o grant;
//           HMASTER_o/HMASTDATA_o address/data owner; HMASTLOCK_o lock flag.
module ahb_bus_arbiter
    import ahb_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int MID_W          = 2,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic                   HCLK_i,
    input  logic                   HRESETn_i,
    input  logic [NUM_MASTERS-1:0] HBUSREQ_i,
    input  logic [NUM_MASTERS-1:0] HLOCK_i,
    input  logic [1:0]             HTRANS_i,
    input  logic [2:0]             HBURST_i,
    input  logic                   HREADY_i,
    output logic [NUM_MASTERS-1:0] HGRANT_o,
    output logic [MID_W-1:0]       HMASTER_o,
    output logic [MID_W-1:0]       HMASTDATA_o,
    output logic                   HMASTLOCK_o
);

    localparam logic [NUM_MASTERS-1:0] DEF_GNT = NUM_MASTERS'(1) << DEFAULT_MASTER;
    localparam logic [MID_W-1:0]       DEF_ID  = MID_W'(DEFAULT_MASTER);

    function automatic logic [MID_W-1:0] oh2idx(input logic [NUM_MASTERS-1:0] oh);
        logic [MID_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (oh[i]) idx = idx | MID_W'(i);
        end
        return idx;
    endfunction

    arb_state_e             state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [MID_W-1:0]       hmaster_q;
    logic [MID_W-1:0]       hmastdata_q;
    logic                   hmastlock_q;

    logic [MID_W-1:0]       grant_idx;
    logic                   owner_lock;
    logic                   owner_req;
    logic [4:0]             beats;
    logic                   regrant;

    logic [MID_W-1:0]       pick_ptr;
    logic [NUM_MASTERS-1:0] pick_gnt;
    logic                   pick_vld;

    assign grant_idx  = oh2idx(grant_q);
    // Burst/lock decisions follow the master that owns the address phase,
    // since that is whose HTRANS/HBURST is on the bus.
    assign owner_lock = HLOCK_i[hmaster_q];
    assign owner_req  = HBUSREQ_i[hmaster_q];
    assign beats      = burst_beats(HBURST_i);

    // Sequence FSM: every transition needs HREADY_i so wait states are
    // invisible to it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (HREADY_i) begin
            unique case (state_q)
                ST_ARB: begin
                    if (HTRANS_i == HTRANS_NONSEQ) begin
                        if (owner_lock) begin
                            state_d = ST_LOCK;
                        end else if (HBURST_i == HBURST_INCR) begin
                            state_d = ST_INCR;
                        end else if (HBURST_i != HBURST_SINGLE) begin
                            state_d = ST_BURST;
                            cnt_d   = 4'(beats - 5'd1);
                        end
                    end
                end
                ST_BURST: begin
                    case (HTRANS_i)
                        // The SEQ that takes the counter to zero is the last beat.
                        HTRANS_SEQ: begin
                            if (cnt_q <= 4'd1) begin
                                state_d = ST_ARB;
                                cnt_d   = '0;
                            end else begin
                                cnt_d = cnt_q - 4'd1;
                            end
                        end
                        HTRANS_BUSY: begin
                            cnt_d = cnt_q;
                        end
                        // IDLE or a fresh NONSEQ ends the burst early.
                        HTRANS_IDLE, HTRANS_NONSEQ: begin
                            state_d = ST_ARB;
                            cnt_d   = '0;
                        end
                        default: begin
                            cnt_d = cnt_q;
                        end
                    endcase
                end
                ST_INCR: begin
                    if (!owner_req) state_d = ST_ARB;
                end
                ST_LOCK: begin
                    if (!owner_lock) state_d = ST_ARB;
                end
                default: begin
                    state_d = ST_ARB;
                end
            endcase
        end
    end

    // The grant may only move on a ready edge that leaves the FSM in ARB,
    // including the edge that ends a burst or lock.
    assign regrant = HREADY_i && (state_d == ST_ARB);

    always_comb begin
        grant_d = grant_q;
        if (regrant) begin
            grant_d = pick_vld ? pick_gnt : DEF_GNT;
        end
    end

`ifdef AHB_ARB_FIXED_PRIO_EN
    // Pointer at the top index masks everything, so the picker falls back
    // to plain lowest-index priority.
    assign pick_ptr = MID_W'(NUM_MASTERS - 1);
`else
    logic [MID_W-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (regrant && pick_vld) begin
            ptr_d = oh2idx(pick_gnt);
        end
    end

    always_ff @(posedge HCLK_i or negedge HRESETn_i) begin
        if (!HRESETn_i) begin
            ptr_q <= DEF_ID;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign pick_ptr = ptr_q;
`endif

    ahb_rr_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .MID_W       (MID_W)
    ) u_picker (
        .req_i (HBUSREQ_i),
        .ptr_i (pick_ptr),
        .gnt_o (pick_gnt),
        .vld_o (pick_vld)
    );

    always_ff @(posedge HCLK_i or negedge HRESETn_i) begin
        if (!HRESETn_i) begin
            state_q     <= ST_ARB;
            cnt_q       <= '0;
            grant_q     <= DEF_GNT;
            hmaster_q   <= DEF_ID;
            hmastdata_q <= DEF_ID;
            hmastlock_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            // Ownership pipeline: grant -> address phase -> data phase.
            if (HREADY_i) begin
                hmaster_q   <= grant_idx;
                hmastdata_q <= hmaster_q;
                hmastlock_q <= HLOCK_i[grant_idx];
            end
        end
    end

    assign HGRANT_o    = grant_q;
    assign HMASTER_o   = hmaster_q;
    assign HMASTDATA_o = hmastdata_q;
    assign HMASTLOCK_o = hmastlock_q;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Bench for ahb_bus_arbiter: vector table, directed corner sequences and a
// randomized run against a transaction-level reference model.
module tb_ahb_bus_arbiter;

    localparam int NM = 4;

    localparam int M_FREE   = 0;
    localparam int M_FIXED  = 1;
    localparam int M_UNDEF  = 2;
    localparam int M_LOCKED = 3;

    logic          HCLK_i = 1'b0;
    logic          HRESETn_i;
    logic [NM-1:0] HBUSREQ_i;
    logic [NM-1:0] HLOCK_i;
    logic [1:0]    HTRANS_i;
    logic [2:0]    HBURST_i;
    logic          HREADY_i;
    logic [NM-1:0] HGRANT_o;
    logic [1:0]    HMASTER_o;
    logic [1:0]    HMASTDATA_o;
    logic          HMASTLOCK_o;

    ahb_bus_arbiter #(
        .NUM_MASTERS    (NM),
        .MID_W          (2),
        .DEFAULT_MASTER (0)
    ) dut (
        .HCLK_i      (HCLK_i),
        .HRESETn_i   (HRESETn_i),
        .HBUSREQ_i   (HBUSREQ_i),
        .HLOCK_i     (HLOCK_i),
        .HTRANS_i    (HTRANS_i),
        .HBURST_i    (HBURST_i),
        .HREADY_i    (HREADY_i),
        .HGRANT_o    (HGRANT_o),
        .HMASTER_o   (HMASTER_o),
        .HMASTDATA_o (HMASTDATA_o),
        .HMASTLOCK_o (HMASTLOCK_o)
    );

    always #5 HCLK_i = ~HCLK_i;

    typedef struct {
        logic [3:0] req;
        logic [3:0] lock;
        logic [1:0] trans;
        logic [2:0] burst;
        logic       rdy;
        logic [3:0] e_gnt;
        logic [1:0] e_mst;
        logic [1:0] e_dat;
        logic       e_ml;
    } vec_t;

    vec_t tbl[18];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: who holds the bus, what kind of sequence is running
    // and how many SEQ beats of a fixed burst are still owed.
    int   m_gnt, m_ptr, m_mst, m_dat, m_mode, m_left;
    logic m_ml;

    function automatic vec_t mkv(input logic [3:0] req, input logic [3:0] lock,
                                 input logic [1:0] tr, input logic [2:0] bu,
                                 input logic rdy, input logic [3:0] g,
                                 input logic [1:0] m, input logic [1:0] d,
                                 input logic ml);
        vec_t v;
        v.req = req; v.lock = lock; v.trans = tr; v.burst = bu; v.rdy = rdy;
        v.e_gnt = g; v.e_mst = m; v.e_dat = d; v.e_ml = ml;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic mdl_reset();
        m_gnt = 0; m_ptr = 0; m_mst = 0; m_dat = 0; m_ml = 1'b0;
        m_mode = M_FREE; m_left = 0;
    endtask

    function automatic int mdl_pick(input logic [3:0] req);
`ifdef AHB_ARB_FIXED_PRIO_EN
        for (int i = 0; i < NM; i++) begin
            if (req[i]) return i;
        end
`else
        for (int k = 1; k <= NM; k++) begin
            if (req[(m_ptr + k) % NM]) return (m_ptr + k) % NM;
        end
`endif
        return -1;
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic mdl_edge();
        int nmode, nleft, w, og, tr, bu;
        if (HREADY_i !== 1'b1) return;
        nmode = m_mode; nleft = m_left; og = m_gnt;
        tr = int'(HTRANS_i); bu = int'(HBURST_i);
        case (m_mode)
            M_FREE: begin
                if (tr == 2) begin
                    if (HLOCK_i[m_mst]) nmode = M_LOCKED;
                    else if (bu == 1) nmode = M_UNDEF;
                    else if (bu >= 2) begin
                        nmode = M_FIXED;
                        nleft = (4 << ((bu >> 1) - 1)) - 1;
                    end
                end
            end
            M_FIXED: begin
                if (tr == 3) begin
                    nleft = m_left - 1;
                    if (nleft == 0) nmode = M_FREE;
                end else if (tr != 1) begin
                    nmode = M_FREE; nleft = 0;
                end
            end
            M_UNDEF:  if (!HBUSREQ_i[m_mst]) nmode = M_FREE;
            default:  if (!HLOCK_i[m_mst])   nmode = M_FREE;
        endcase
        m_mode = nmode; m_left = nleft;
        if (nmode == M_FREE) begin
            w = mdl_pick(HBUSREQ_i);
            if (w >= 0) begin
                m_gnt = w; m_ptr = w;
            end else begin
                m_gnt = 0;
            end
        end
        m_dat = m_mst;
        m_mst = og;
        m_ml  = HLOCK_i[og];
    endtask

    task automatic apply(input string nm, input vec_t v);
        HBUSREQ_i = v.req; HLOCK_i = v.lock; HTRANS_i = v.trans;
        HBURST_i = v.burst; HREADY_i = v.rdy;
        @(posedge HCLK_i);
        #1;
        mdl_edge();
        chk({nm, "_grant"}, 32'(HGRANT_o),    32'(v.e_gnt));
        chk({nm, "_hmst"},  32'(HMASTER_o),   32'(v.e_mst));
        chk({nm, "_hdat"},  32'(HMASTDATA_o), 32'(v.e_dat));
        chk({nm, "_hlock"}, 32'(HMASTLOCK_o), 32'(v.e_ml));
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_grant"}, 32'(HGRANT_o),    32'h1);
        chk({nm, "_hmst"},  32'(HMASTER_o),   32'h0);
        chk({nm, "_hdat"},  32'(HMASTDATA_o), 32'h0);
        chk({nm, "_hlock"}, 32'(HMASTLOCK_o), 32'h0);
    endtask

    initial begin
        // Rotation, wait-state freeze and an INCR4 hold (BUSY inserted,
        // owner drops its request mid burst).
`ifdef AHB_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 9; i++)
            tbl[i] = mkv(4'b1111, 4'b0, 2'b10, 3'b000, (i == 5 || i == 6) ? 1'b0 : 1'b1,
                         4'b0001, 2'd0, 2'd0, 1'b0);
        tbl[9]  = mkv(4'b0100, 4'b0, 2'b00, 3'b000, 1'b1, 4'b0100, 2'd0, 2'd0, 1'b0);
        tbl[10] = mkv(4'b0100, 4'b0, 2'b00, 3'b000, 1'b1, 4'b0100, 2'd2, 2'd0, 1'b0);
`else
        tbl[0]  = mkv(4'b1111, 4'b0, 2'b10, 3'b000, 1'b1, 4'b0010, 2'd0, 2'd0, 1'b0);
        tbl[1]  = mkv(4'b1111, 4'b0, 2'b10, 3'b000, 1'b1, 4'b0100, 2'd1, 2'd0, 1'b0);
        tbl[2]  = mkv(4'b1111, 4'b0, 2'b10, 3'b000, 1'b1, 4'b1000, 2'd2, 2'd1, 1'b0);
        tbl[3]  = mkv(4'b1111, 4'b0, 2'b10, 3'b000, 1'b1, 4'b0001, 2'd3, 2'd2, 1'b0);
        tbl[4]  = mkv(4'b1111, 4'b0, 2'b10, 3'b000, 1'b1, 4'b0010, 2'd0, 2'd3, 1'b0);
        tbl[5]  = mkv(4'b1111, 4'b0, 2'b10, 3'b000, 1'b0, 4'b0010, 2'd0, 2'd3, 1'b0);
        tbl[6]  = mkv(4'b1111, 4'b0, 2'b10, 3'b000, 1'b0, 4'b0010, 2'd0, 2'd3, 1'b0);
        tbl[7]  = mkv(4'b1111, 4'b0, 2'b10, 3'b000, 1'b1, 4'b0100, 2'd1, 2'd0, 1'b0);
        tbl[8]  = mkv(4'b1111, 4'b0, 2'b10, 3'b000, 1'b1, 4'b1000, 2'd2, 2'd1, 1'b0);
        tbl[9]  = mkv(4'b0100, 4'b0, 2'b00, 3'b000, 1'b1, 4'b0100, 2'd3, 2'd2, 1'b0);
        tbl[10] = mkv(4'b0100, 4'b0, 2'b00, 3'b000, 1'b1, 4'b0100, 2'd2, 2'd3, 1'b0);
`endif
        tbl[11] = mkv(4'b0110, 4'b0, 2'b10, 3'b011, 1'b1, 4'b0100, 2'd2, 2'd2, 1'b0);
        tbl[12] = mkv(4'b0010, 4'b0, 2'b11, 3'b011, 1'b1, 4'b0100, 2'd2, 2'd2, 1'b0);
        tbl[13] = mkv(4'b0010, 4'b0, 2'b01, 3'b011, 1'b1, 4'b0100, 2'd2, 2'd2, 1'b0);
        tbl[14] = mkv(4'b0010, 4'b0, 2'b11, 3'b011, 1'b1, 4'b0100, 2'd2, 2'd2, 1'b0);
        tbl[15] = mkv(4'b0010, 4'b0, 2'b01, 3'b011, 1'b1, 4'b0100, 2'd2, 2'd2, 1'b0);
        tbl[16] = mkv(4'b0010, 4'b0, 2'b11, 3'b011, 1'b1, 4'b0010, 2'd2, 2'd2, 1'b0);
        tbl[17] = mkv(4'b0010, 4'b0, 2'b00, 3'b000, 1'b1, 4'b0010, 2'd1, 2'd2, 1'b0);

        HRESETn_i = 1'b1; HBUSREQ_i = '0; HLOCK_i = '0;
        HTRANS_i = 2'b00; HBURST_i = 3'b000; HREADY_i = 1'b1;
        #2 HRESETn_i = 1'b0;
        mdl_reset();
        repeat (2) @(posedge HCLK_i);
        #1;
        chk_reset_vals("reset");
        #2 HRESETn_i = 1'b1;

        for (int i = 0; i < 18; i++) begin
            apply($sformatf("tbl%0d", i), tbl[i]);
        end

        // Locked sequence on M3 with wait states; released only once HLOCK
        // drops and HREADY is high.
        apply("lk_grant", mkv(4'b1000, 4'b0000, 2'b00, 3'b000, 1'b1, 4'b1000, 2'd1, 2'd1, 1'b0));
        apply("lk_req",   mkv(4'b1000, 4'b1000, 2'b00, 3'b000, 1'b1, 4'b1000, 2'd3, 2'd1, 1'b1));
        apply("lk_start", mkv(4'b1001, 4'b1000, 2'b10, 3'b000, 1'b1, 4'b1000, 2'd3, 2'd3, 1'b1));
        for (int i = 0; i < 3; i++)
            apply($sformatf("lk_wait%0d", i),
                  mkv(4'b1001, 4'b1000, 2'b00, 3'b000, 1'b0, 4'b1000, 2'd3, 2'd3, 1'b1));
        apply("lk_drop_wait", mkv(4'b1001, 4'b0000, 2'b00, 3'b000, 1'b0, 4'b1000, 2'd3, 2'd3, 1'b1));
        apply("lk_release",   mkv(4'b1001, 4'b0000, 2'b00, 3'b000, 1'b1, 4'b0001, 2'd3, 2'd3, 1'b0));

        // HLOCK on a master that does not own the bus has no effect.
        apply("nol_park",  mkv(4'b0001, 4'b0000, 2'b00, 3'b000, 1'b1, 4'b0001, 2'd0, 2'd3, 1'b0));
        apply("nol_xfer",  mkv(4'b0001, 4'b0100, 2'b10, 3'b000, 1'b1, 4'b0001, 2'd0, 2'd0, 1'b0));
        apply("nol_move",  mkv(4'b0100, 4'b0100, 2'b00, 3'b000, 1'b1, 4'b0100, 2'd0, 2'd0, 1'b0));

        // Early-terminated INCR8: IDLE after one SEQ frees the bus.
        apply("et_own",   mkv(4'b0100, 4'b0000, 2'b00, 3'b000, 1'b1, 4'b0100, 2'd2, 2'd0, 1'b0));
        apply("et_start", mkv(4'b0110, 4'b0000, 2'b10, 3'b101, 1'b1, 4'b0100, 2'd2, 2'd2, 1'b0));
        apply("et_seq",   mkv(4'b0110, 4'b0000, 2'b11, 3'b101, 1'b1, 4'b0100, 2'd2, 2'd2, 1'b0));
        apply("et_idle",  mkv(4'b0110, 4'b0000, 2'b00, 3'b101, 1'b1, 4'b0010, 2'd2, 2'd2, 1'b0));

        // Reset asserted during beat 5 of an INCR8.
        apply("rb_own0",  mkv(4'b0100, 4'b0000, 2'b00, 3'b000, 1'b1, 4'b0100, 2'd1, 2'd2, 1'b0));
        apply("rb_own1",  mkv(4'b0100, 4'b0000, 2'b00, 3'b000, 1'b1, 4'b0100, 2'd2, 2'd1, 1'b0));
        apply("rb_start", mkv(4'b0110, 4'b0000, 2'b10, 3'b101, 1'b1, 4'b0100, 2'd2, 2'd2, 1'b0));
        for (int i = 0; i < 4; i++)
            apply($sformatf("rb_seq%0d", i),
                  mkv(4'b0110, 4'b0000, 2'b11, 3'b101, 1'b1, 4'b0100, 2'd2, 2'd2, 1'b0));
        #2 HRESETn_i = 1'b0;
        #1 chk_reset_vals("rb_async");
        mdl_reset();
        #2 HRESETn_i = 1'b1;
        apply("rb_after0", mkv(4'b0010, 4'b0000, 2'b00, 3'b000, 1'b1, 4'b0010, 2'd0, 2'd0, 1'b0));
        apply("rb_after1", mkv(4'b0010, 4'b0000, 2'b00, 3'b000, 1'b1, 4'b0010, 2'd1, 2'd0, 1'b0));

        // Randomized traffic against the model.
        for (int c = 0; c < 800; c++) begin
            int r;
            if ($urandom_range(0, 2) == 0) HBUSREQ_i = 4'($urandom);
            if ($urandom_range(0, 5) == 0) HLOCK_i = 4'($urandom) & 4'($urandom);
            r = $urandom_range(0, 9);
            if (r < 2)      HTRANS_i = 2'b00;
            else if (r < 3) HTRANS_i = 2'b01;
            else if (r < 5) begin
                HTRANS_i = 2'b10;
                HBURST_i = 3'($urandom);
            end else        HTRANS_i = 2'b11;
            HREADY_i = ($urandom_range(0, 3) != 0);
            @(posedge HCLK_i);
            #1;
            mdl_edge();
            chk("rnd_grant", 32'(HGRANT_o),    32'(4'b0001 << m_gnt));
            chk("rnd_hmst",  32'(HMASTER_o),   32'(m_mst));
            chk("rnd_hdat",  32'(HMASTDATA_o), 32'(m_dat));
            chk("rnd_hlock", 32'(HMASTLOCK_o), 32'(m_ml));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
